mips_multicycle_ctrl: RTL and testbench

- Multi-cycle MIPS control unit; replaces single-cycle decode with a Moore FSM that sequences fetch/decode/execute/memory/writeback over several clocks.
- Sits between the instruction register (IR) and the shared-memory multi-cycle datapath. Drives mux selects, write enables and ALU control each cycle.
- Adds over the single-cycle decoder:
  - memory ready handshake;
  - jump support;
  - a wait timeout;
  - an illegal-opcode trap mode.

---
 rtl/mips_multicycle_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control unit: Moore FSM sequencing fetch/decode/execute/memory/writeback,
// with memory-ready wait states, an optional wait timeout and an illegal-opcode trap.
module mips_multicycle_ctrl #(
   parameter int ALUCTRL_W   = 6,
   parameter bit TRAP_HALT   = 1'b0,
   parameter int MEM_TIMEOUT = 0,
   parameter int CNT_W       = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [31:0]          instr,
   input  logic                 zero,
   input  logic                 mem_ready,
   output logic                 mem_read,
   output logic                 mem_write,
   output logic                 iord,
   output logic                 ir_write,
   output logic                 pc_en,
   output logic [1:0]           pc_src,
   output logic                 reg_write,
   output logic                 reg_dst,
   output logic                 mem_to_reg,
   output logic                 alu_src_a,
   output logic [1:0]           alu_src_b,
   output logic [ALUCTRL_W-1:0] alu_ctrl,
   output logic                 illegal_op,
   output logic                 mem_err,
   output logic                 instr_done,
   output logic [3:0]           state
);

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_ALUWB  = 4'd7,
      S_BRANCH = 4'd8,  S_ADDIEX = 4'd9,  S_ADDIWB = 4'd10, S_JUMP   = 4'd11,
      S_HALT   = 4'd12
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [ALUCTRL_W-1:0] ALU_ADD = ALUCTRL_W'(6'b100000);
   localparam logic [ALUCTRL_W-1:0] ALU_SUB = ALUCTRL_W'(6'b100010);

   localparam int               TO_LAST_I = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;
   localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TO_LAST_I);
   localparam state_t           TRAP_DEST = TRAP_HALT ? S_HALT : S_FETCH;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] wait_cnt;
   logic             wait_state, timeout;
   logic [5:0]       opcode;
   logic             unused_instr_bits;

   assign opcode            = instr[31:26];
   assign unused_instr_bits = ^instr[25:ALUCTRL_W];
   assign wait_state        = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
   assign timeout           = (MEM_TIMEOUT > 0) && wait_state && !mem_ready && (wait_cnt == TO_LAST);
   assign state             = reset ? 4'd0 : state_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_FETCH;
         wait_cnt <= '0;
      end else begin
         state_q <= state_d;
         // A timeout in FETCH re-enters FETCH without a state change, so clear explicitly.
         if ((state_d != state_q) || timeout)
            wait_cnt <= '0;
         else if (wait_state && !mem_ready)
            wait_cnt <= wait_cnt + 1'b1;
      end
   end

   always_comb begin
      state_d    = state_q;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      iord       = 1'b0;
      ir_write   = 1'b0;
      pc_en      = 1'b0;
      pc_src     = 2'd0;
      reg_write  = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'd0;
      alu_ctrl   = '0;
      illegal_op = 1'b0;
      mem_err    = 1'b0;
      instr_done = 1'b0;
      if (!reset) begin
         unique case (state_q)
            S_FETCH: begin
               mem_read  = 1'b1;
               alu_src_b = 2'd1;
               alu_ctrl  = ALU_ADD;
               if (mem_ready) begin
                  ir_write = 1'b1;
                  pc_en    = 1'b1;
                  state_d  = S_DECODE;
               end else if (timeout) begin
                  mem_err = 1'b1;
                  state_d = TRAP_DEST;
               end
            end
            S_DECODE: begin
               alu_src_b = 2'd3;
               alu_ctrl  = ALU_ADD;
               case (opcode)
                  OP_RTYPE:       state_d = S_EXEC;
                  OP_LW, OP_SW:   state_d = S_MEMADR;
                  OP_BEQ, OP_BNE: state_d = S_BRANCH;
                  OP_ADDI:        state_d = S_ADDIEX;
                  OP_J:           state_d = S_JUMP;
                  default: begin
                     illegal_op = 1'b1;
                     state_d    = TRAP_DEST;
                  end
               endcase
            end
            S_MEMADR: begin
               alu_src_a = 1'b1;
               alu_src_b = 2'd2;
               alu_ctrl  = ALU_ADD;
               state_d   = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
               mem_read = 1'b1;
               iord     = 1'b1;
               if (mem_ready) state_d = S_MEMWB;
               else if (timeout) begin
                  mem_err = 1'b1;
                  state_d = TRAP_DEST;
               end
            end
            S_MEMWB: begin
               reg_write  = 1'b1;
               mem_to_reg = 1'b1;
               instr_done = 1'b1;
               state_d    = S_FETCH;
            end
            S_MEMWR: begin
               mem_write = 1'b1;
               iord      = 1'b1;
               if (mem_ready) begin
                  instr_done = 1'b1;
                  state_d    = S_FETCH;
               end else if (timeout) begin
                  mem_err = 1'b1;
                  state_d = TRAP_DEST;
               end
            end
            S_EXEC: begin
               alu_src_a = 1'b1;
               alu_ctrl  = instr[ALUCTRL_W-1:0];
               state_d   = S_ALUWB;
            end
            S_ALUWB: begin
               reg_write  = 1'b1;
               reg_dst    = 1'b1;
               instr_done = 1'b1;
               state_d    = S_FETCH;
            end
            S_BRANCH: begin
               alu_src_a  = 1'b1;
               alu_ctrl   = ALU_SUB;
               pc_src     = 2'd1;
               instr_done = 1'b1;
               pc_en      = (opcode == OP_BNE) ? ~zero : zero;
               state_d    = S_FETCH;
            end
            S_ADDIEX: begin
               alu_src_a = 1'b1;
               alu_src_b = 2'd2;
               alu_ctrl  = ALU_ADD;
               state_d   = S_ADDIWB;
            end
            S_ADDIWB: begin
               reg_write  = 1'b1;
               instr_done = 1'b1;
               state_d    = S_FETCH;
            end
            S_JUMP: begin
               pc_en      = 1'b1;
               pc_src     = 2'd2;
               instr_done = 1'b1;
               state_d    = S_FETCH;
            end
            default: state_d = state_q;
         endcase
      end
   end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: one instance resumes on traps with a 4-cycle
// memory timeout, the other halts on traps with the timeout disabled.
module tb_mips_multicycle_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] instr = '0;
   logic        zero = 1'b0;
   logic        mem_ready = 1'b1;

   logic       mem_read, mem_write, iord, ir_write, pc_en, reg_write, reg_dst, mem_to_reg;
   logic       alu_src_a, illegal_op, mem_err, instr_done;
   logic [1:0] pc_src, alu_src_b;
   logic [5:0] alu_ctrl;
   logic [3:0] state;

   logic       h_mem_read, h_mem_write, h_iord, h_ir_write, h_pc_en, h_reg_write, h_reg_dst;
   logic       h_mem_to_reg, h_alu_src_a, h_illegal_op, h_mem_err, h_instr_done;
   logic [1:0] h_pc_src, h_alu_src_b;
   logic [5:0] h_alu_ctrl;
   logic [3:0] h_state;

   logic [25:0] all_out, h_all_out;
   assign all_out = {mem_read, mem_write, iord, ir_write, pc_en, pc_src, reg_write, reg_dst,
                     mem_to_reg, alu_src_a, alu_src_b, alu_ctrl, illegal_op, mem_err, instr_done, state};
   assign h_all_out = {h_mem_read, h_mem_write, h_iord, h_ir_write, h_pc_en, h_pc_src, h_reg_write,
                       h_reg_dst, h_mem_to_reg, h_alu_src_a, h_alu_src_b, h_alu_ctrl, h_illegal_op,
                       h_mem_err, h_instr_done, h_state};

   int n_checks = 0;
   int n_fail   = 0;

   mips_multicycle_ctrl #(.ALUCTRL_W(6), .TRAP_HALT(1'b0), .MEM_TIMEOUT(4), .CNT_W(8)) dut (
      .clk(clk), .reset(reset), .instr(instr), .zero(zero), .mem_ready(mem_ready),
      .mem_read(mem_read), .mem_write(mem_write), .iord(iord), .ir_write(ir_write),
      .pc_en(pc_en), .pc_src(pc_src), .reg_write(reg_write), .reg_dst(reg_dst),
      .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .alu_ctrl(alu_ctrl), .illegal_op(illegal_op), .mem_err(mem_err),
      .instr_done(instr_done), .state(state)
   );

   mips_multicycle_ctrl #(.ALUCTRL_W(6), .TRAP_HALT(1'b1), .MEM_TIMEOUT(0), .CNT_W(8)) dut_h (
      .clk(clk), .reset(reset), .instr(instr), .zero(zero), .mem_ready(mem_ready),
      .mem_read(h_mem_read), .mem_write(h_mem_write), .iord(h_iord), .ir_write(h_ir_write),
      .pc_en(h_pc_en), .pc_src(h_pc_src), .reg_write(h_reg_write), .reg_dst(h_reg_dst),
      .mem_to_reg(h_mem_to_reg), .alu_src_a(h_alu_src_a), .alu_src_b(h_alu_src_b),
      .alu_ctrl(h_alu_ctrl), .illegal_op(h_illegal_op), .mem_err(h_mem_err),
      .instr_done(h_instr_done), .state(h_state)
   );

   always #5 clk = ~clk;

   // Leaves the bench at the negedge of the first post-reset FETCH cycle.
   task automatic do_reset();
      @(negedge clk); reset = 1'b1;
      @(negedge clk); reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; mem_ready = 1'b1; instr = '0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); #1;
         n_checks++;
         if (all_out !== 26'd0) begin
            n_fail++; $display("FAIL reset_outputs cyc%0d: got %h expected 0", i, all_out);
         end
         n_checks++;
         if (h_all_out !== 26'd0) begin
            n_fail++; $display("FAIL reset_outputs_h cyc%0d: got %h expected 0", i, h_all_out);
         end
      end
      @(negedge clk); reset = 1'b0; #1;
      n_checks++;
      if ({state, mem_read, iord, ir_write, alu_src_b, alu_ctrl} !== {4'd0, 1'b1, 1'b0, 1'b1, 2'd1, 6'h20}) begin
         n_fail++; $display("FAIL reset_first_fetch: got st=%0d rd=%b iord=%b irw=%b srcb=%0d alu=%h expected 0 1 0 1 1 20",
                            state, mem_read, iord, ir_write, alu_src_b, alu_ctrl);
      end
      @(negedge clk);
   endtask

   task automatic test_rtype();
      logic [31:0] codes [2] = '{32'h012A4020, 32'h012A4025};
      do_reset();
      for (int i = 0; i < 2; i++) begin
         instr = codes[i]; mem_ready = 1'b1; #1;
         n_checks++;
         if ({state, ir_write, pc_en, pc_src} !== {4'd0, 1'b1, 1'b1, 2'd0}) begin
            n_fail++; $display("FAIL rtype_fetch[%0d]: got st=%0d irw=%b pcen=%b pcsrc=%0d expected 0 1 1 0", i, state, ir_write, pc_en, pc_src);
         end
         @(negedge clk); #1;
         n_checks++;
         if ({state, alu_src_a, alu_src_b, alu_ctrl, reg_write} !== {4'd1, 1'b0, 2'd3, 6'h20, 1'b0}) begin
            n_fail++; $display("FAIL rtype_decode[%0d]: got st=%0d srca=%b srcb=%0d alu=%h rw=%b expected 1 0 3 20 0", i, state, alu_src_a, alu_src_b, alu_ctrl, reg_write);
         end
         @(negedge clk); #1;
         n_checks++;
         if ({state, alu_src_a, alu_src_b, alu_ctrl, instr_done} !== {4'd6, 1'b1, 2'd0, (i == 0) ? 6'h20 : 6'h25, 1'b0}) begin
            n_fail++; $display("FAIL rtype_exec[%0d]: got st=%0d srca=%b srcb=%0d alu=%h done=%b expected 6 1 0 %h 0", i, state, alu_src_a, alu_src_b, alu_ctrl, instr_done, (i == 0) ? 6'h20 : 6'h25);
         end
         @(negedge clk); #1;
         n_checks++;
         if ({state, reg_write, reg_dst, mem_to_reg, instr_done, pc_en} !== {4'd7, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL rtype_aluwb[%0d]: got st=%0d rw=%b dst=%b m2r=%b done=%b pcen=%b expected 7 1 1 0 1 0", i, state, reg_write, reg_dst, mem_to_reg, instr_done, pc_en);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_lw_wait();
      do_reset();
      instr = 32'h8D090004; mem_ready = 1'b1; #1;
      @(negedge clk); #1;
      n_checks++;
      if (state !== 4'd1) begin n_fail++; $display("FAIL lw_decode: got %0d expected 1", state); end
      @(negedge clk); #1;
      n_checks++;
      if ({state, alu_src_a, alu_src_b, alu_ctrl} !== {4'd2, 1'b1, 2'd2, 6'h20}) begin
         n_fail++; $display("FAIL lw_memadr: got st=%0d srca=%b srcb=%0d alu=%h expected 2 1 2 20", state, alu_src_a, alu_src_b, alu_ctrl);
      end
      for (int k = 0; k < 4; k++) begin
         @(negedge clk); mem_ready = (k == 3); #1;
         n_checks++;
         if ({state, mem_read, iord, reg_write, mem_err} !== {4'd3, 1'b1, 1'b1, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL lw_memrd_wait%0d: got st=%0d rd=%b iord=%b rw=%b err=%b expected 3 1 1 0 0", k, state, mem_read, iord, reg_write, mem_err);
         end
      end
      @(negedge clk); #1;
      n_checks++;
      if ({state, reg_write, reg_dst, mem_to_reg, instr_done, mem_read} !== {4'd4, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0}) begin
         n_fail++; $display("FAIL lw_memwb: got st=%0d rw=%b dst=%b m2r=%b done=%b rd=%b expected 4 1 0 1 1 0", state, reg_write, reg_dst, mem_to_reg, instr_done, mem_read);
      end
      @(negedge clk); #1;
      n_checks++;
      if (state !== 4'd0) begin n_fail++; $display("FAIL lw_return_fetch: got %0d expected 0", state); end
      @(negedge clk);
   endtask

   task automatic test_branch();
      logic [31:0] codes [3] = '{32'h11090003, 32'h15090003, 32'h15090003};
      logic        zs    [3] = '{1'b1, 1'b1, 1'b0};
      logic        exp_pc[3] = '{1'b1, 1'b0, 1'b1};
      do_reset();
      for (int i = 0; i < 3; i++) begin
         instr = codes[i]; zero = zs[i]; mem_ready = 1'b1; #1;
         @(negedge clk); #1;
         n_checks++;
         if (state !== 4'd1) begin n_fail++; $display("FAIL branch_decode[%0d]: got %0d expected 1", i, state); end
         @(negedge clk); #1;
         n_checks++;
         if ({state, pc_en, pc_src, alu_src_a, alu_src_b, alu_ctrl, instr_done} !== {4'd8, exp_pc[i], 2'd1, 1'b1, 2'd0, 6'h22, 1'b1}) begin
            n_fail++; $display("FAIL branch_exec[%0d]: got st=%0d pcen=%b pcsrc=%0d srca=%b srcb=%0d alu=%h done=%b expected 8 %b 1 1 0 22 1",
                               i, state, pc_en, pc_src, alu_src_a, alu_src_b, alu_ctrl, instr_done, exp_pc[i]);
         end
         @(negedge clk);
      end
      zero = 1'b0;
   endtask

   task automatic test_back_to_back();
      do_reset();
      // sw, addi, j issued without gaps
      instr = 32'hAD090004; mem_ready = 1'b1; #1;
      @(negedge clk); @(negedge clk); #1;
      n_checks++;
      if (state !== 4'd2) begin n_fail++; $display("FAIL sw_memadr: got %0d expected 2", state); end
      @(negedge clk); #1;
      n_checks++;
      if ({state, mem_write, mem_read, iord, instr_done} !== {4'd5, 1'b1, 1'b0, 1'b1, 1'b1}) begin
         n_fail++; $display("FAIL sw_memwr: got st=%0d wr=%b rd=%b iord=%b done=%b expected 5 1 0 1 1", state, mem_write, mem_read, iord, instr_done);
      end
      @(negedge clk); instr = 32'h21090005; #1;
      n_checks++;
      if (state !== 4'd0) begin n_fail++; $display("FAIL addi_fetch: got %0d expected 0", state); end
      @(negedge clk); @(negedge clk); #1;
      n_checks++;
      if ({state, alu_src_a, alu_src_b, alu_ctrl} !== {4'd9, 1'b1, 2'd2, 6'h20}) begin
         n_fail++; $display("FAIL addi_ex: got st=%0d srca=%b srcb=%0d alu=%h expected 9 1 2 20", state, alu_src_a, alu_src_b, alu_ctrl);
      end
      @(negedge clk); #1;
      n_checks++;
      if ({state, reg_write, reg_dst, mem_to_reg, instr_done} !== {4'd10, 1'b1, 1'b0, 1'b0, 1'b1}) begin
         n_fail++; $display("FAIL addi_wb: got st=%0d rw=%b dst=%b m2r=%b done=%b expected 10 1 0 0 1", state, reg_write, reg_dst, mem_to_reg, instr_done);
      end
      @(negedge clk); instr = 32'h08000010; #1;
      @(negedge clk); @(negedge clk); #1;
      n_checks++;
      if ({state, pc_en, pc_src, instr_done, reg_write} !== {4'd11, 1'b1, 2'd2, 1'b1, 1'b0}) begin
         n_fail++; $display("FAIL jump: got st=%0d pcen=%b pcsrc=%0d done=%b rw=%b expected 11 1 2 1 0", state, pc_en, pc_src, instr_done, reg_write);
      end
      @(negedge clk); #1;
      n_checks++;
      if (state !== 4'd0) begin n_fail++; $display("FAIL jump_return_fetch: got %0d expected 0", state); end
      @(negedge clk);
   endtask

   task automatic test_illegal();
      do_reset();
      instr = 32'hFC000000; mem_ready = 1'b1; #1;
      @(negedge clk); #1;
      n_checks++;
      if ({state, illegal_op, alu_src_b} !== {4'd1, 1'b1, 2'd3}) begin
         n_fail++; $display("FAIL illegal_pulse: got st=%0d ill=%b srcb=%0d expected 1 1 3", state, illegal_op, alu_src_b);
      end
      n_checks++;
      if ({h_state, h_illegal_op} !== {4'd1, 1'b1}) begin
         n_fail++; $display("FAIL illegal_pulse_h: got st=%0d ill=%b expected 1 1", h_state, h_illegal_op);
      end
      @(negedge clk); #1;
      n_checks++;
      if ({state, illegal_op, mem_read} !== {4'd0, 1'b0, 1'b1}) begin
         n_fail++; $display("FAIL illegal_resume: got st=%0d ill=%b rd=%b expected 0 0 1", state, illegal_op, mem_read);
      end
      for (int k = 0; k < 3; k++) begin
         n_checks++;
         if (h_all_out !== 26'd12) begin
            n_fail++; $display("FAIL illegal_halt_h cyc%0d: got %h expected 00000c", k, h_all_out);
         end
         @(negedge clk); #1;
      end
      reset = 1'b1; #1;
      n_checks++;
      if (h_all_out !== 26'd0) begin n_fail++; $display("FAIL halt_reset_h: got %h expected 0", h_all_out); end
      @(negedge clk); reset = 1'b0; instr = 32'h012A4020; #1;
      n_checks++;
      if ({h_state, h_mem_read} !== {4'd0, 1'b1}) begin
         n_fail++; $display("FAIL halt_exit_h: got st=%0d rd=%b expected 0 1", h_state, h_mem_read);
      end
      @(negedge clk);
   endtask

   task automatic test_timeout();
      do_reset();
      instr = 32'h012A4020;
      for (int k = 1; k <= 12; k++) begin
         if (k > 1) @(negedge clk);
         mem_ready = (k == 12); #1;
         n_checks++;
         if ({state, mem_read, iord, ir_write, pc_en, mem_err} !==
             {4'd0, 1'b1, 1'b0, k == 12, k == 12, (k == 4) || (k == 8)}) begin
            n_fail++; $display("FAIL timeout_fetch cyc%0d: got st=%0d rd=%b iord=%b irw=%b pcen=%b err=%b expected 0 1 0 %b %b %b",
                               k, state, mem_read, iord, ir_write, pc_en, mem_err, k == 12, k == 12, (k == 4) || (k == 8));
         end
         n_checks++;
         if ({h_state, h_mem_err} !== {4'd0, 1'b0}) begin
            n_fail++; $display("FAIL no_timeout_h cyc%0d: got st=%0d err=%b expected 0 0", k, h_state, h_mem_err);
         end
      end
      @(negedge clk); #1;
      n_checks++;
      if ({state, mem_err} !== {4'd1, 1'b0}) begin
         n_fail++; $display("FAIL ready_wins_decode: got st=%0d err=%b expected 1 0", state, mem_err);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_abort();
      do_reset();
      instr = 32'hAD090004; mem_ready = 1'b1; #1;
      @(negedge clk); @(negedge clk); #1;
      n_checks++;
      if (state !== 4'd2) begin n_fail++; $display("FAIL abort_memadr: got %0d expected 2", state); end
      @(negedge clk); reset = 1'b1; #1;
      n_checks++;
      if (all_out !== 26'd0) begin n_fail++; $display("FAIL abort_forced_zero: got %h expected 0", all_out); end
      @(negedge clk); reset = 1'b0; #1;
      n_checks++;
      if ({state, mem_write, mem_read} !== {4'd0, 1'b0, 1'b1}) begin
         n_fail++; $display("FAIL abort_refetch: got st=%0d wr=%b rd=%b expected 0 0 1", state, mem_write, mem_read);
      end
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_rtype();
      test_lw_wait();
      test_branch();
      test_back_to_back();
      test_illegal();
      test_timeout();
      test_reset_abort();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
